// File: rtl/if_id_reg_bp.sv
// if_id_reg_bp: IF/ID pipeline register with freeze, flush and a deferred-flush FSM.
// Define IFID_STATS_EN to enable the saturating flush/stall statistics counters.
module if_id_reg_bp #(
    parameter int WORD_LEN = 32,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                flush,
    input  logic [WORD_LEN-1:0] PC_in,
    input  logic [WORD_LEN-1:0] instruction_in,
    input  logic                predict_taken_in,
    output logic [WORD_LEN-1:0] PC,
    output logic [WORD_LEN-1:0] instruction,
    output logic                predict_taken,
    output logic                valid,
    output logic                flush_pending,
    output logic [CNT_W-1:0]    flush_count,
    output logic [CNT_W-1:0]    stall_count
);
    typedef enum logic {RUN, PEND} state_t;
    state_t state, next_state;
    logic load_bubble, load_fetch;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= next_state;
    end
    // A flush seen while frozen is parked in PEND until freeze drops
    always_comb begin
        next_state = (state == RUN) ? ((freeze && flush) ? PEND : RUN) : (freeze ? PEND : RUN);
    end
    always_comb begin
        load_bubble = !freeze && (state == PEND || flush);
        load_fetch  = !freeze && state == RUN && !flush;
    end
    assign flush_pending = (state == PEND);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PC            <= '0;
            instruction   <= '0;
            predict_taken <= 1'b0;
            valid         <= 1'b0;
        end else if (load_bubble) begin
            PC            <= '0;
            instruction   <= '0;
            predict_taken <= 1'b0;
            valid         <= 1'b0;
        end else if (load_fetch) begin
            PC            <= PC_in;
            instruction   <= instruction_in;
            predict_taken <= predict_taken_in;
            valid         <= 1'b1;
        end
    end
`ifdef IFID_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_count <= '0;
            stall_count <= '0;
        end else begin
            if (load_bubble && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
            if (freeze && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
        end
    end
`else
    assign flush_count = '0;
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_if_id_reg_bp.sv
// tb_if_id_reg_bp: directed self-checking bench for if_id_reg_bp (CNT_W=4 to reach saturation quickly).
module tb_if_id_reg_bp;
`ifdef IFID_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0, flush = 1'b0, predict_taken_in = 1'b0;
    logic [31:0] PC_in = '0, instruction_in = '0, PC, instruction;
    logic        predict_taken, valid, flush_pending;
    logic [3:0]  flush_count, stall_count;
    int errors = 0, checks = 0;

    if_id_reg_bp #(.WORD_LEN(32), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .PC_in(PC_in), .instruction_in(instruction_in), .predict_taken_in(predict_taken_in),
        .PC(PC), .instruction(instruction), .predict_taken(predict_taken), .valid(valid),
        .flush_pending(flush_pending), .flush_count(flush_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        freeze = 0; flush = 0;
        rst = 0;
        #2;
        rst = 1;
    endtask

    task automatic test_reset();
        PC_in = 32'hDEAD; instruction_in = 32'hBEEF; predict_taken_in = 1;
        edge_step();
        rst = 0;
        #1;
        checks++;
        if ({PC, instruction, predict_taken, valid, flush_pending} !== 67'h0) begin
            errors++; $display("FAIL reset_outputs got PC=%h ins=%h pt=%b v=%b fp=%b exp all zero", PC, instruction, predict_taken, valid, flush_pending);
        end
        checks++;
        if ({flush_count, stall_count} !== 8'h00) begin
            errors++; $display("FAIL reset_counters got fc=%h sc=%h exp 0 0", flush_count, stall_count);
        end
        rst = 1;
    endtask

    task automatic test_load();
        do_reset();
        PC_in = 32'h4; instruction_in = 32'h20010005; predict_taken_in = 1;
        edge_step();
        checks++;
        if ({PC, instruction, predict_taken, valid} !== {32'h4, 32'h20010005, 1'b1, 1'b1}) begin
            errors++; $display("FAIL load PC=%h ins=%h pt=%b v=%b exp 4 20010005 1 1", PC, instruction, predict_taken, valid);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        PC_in = 32'h8; instruction_in = 32'h11111111; predict_taken_in = 0;
        edge_step();
        freeze = 1;
        for (int i = 0; i < 3; i++) begin
            PC_in = 32'h100 + i; instruction_in = 32'hFFFF0000 + i; predict_taken_in = 1;
            edge_step();
            checks++;
            if ({PC, instruction, predict_taken, valid} !== {32'h8, 32'h11111111, 1'b0, 1'b1}) begin
                errors++; $display("FAIL freeze_hold%0d PC=%h ins=%h pt=%b v=%b exp 8 11111111 0 1", i, PC, instruction, predict_taken, valid);
            end
        end
        checks++;
        if (stall_count !== (STATS ? 4'd3 : 4'd0)) begin
            errors++; $display("FAIL freeze_stall_count got %0d exp %0d", stall_count, STATS ? 3 : 0);
        end
        freeze = 0;
    endtask

    task automatic test_flush();
        do_reset();
        PC_in = 32'hC; instruction_in = 32'h12345678; predict_taken_in = 1;
        edge_step();
        flush = 1; PC_in = 32'hAA; instruction_in = 32'h55555555;
        edge_step();
        checks++;
        if ({PC, instruction, predict_taken, valid} !== 66'h0) begin
            errors++; $display("FAIL flush_bubble PC=%h ins=%h pt=%b v=%b exp 0 0 0 0", PC, instruction, predict_taken, valid);
        end
        flush = 0; PC_in = 32'h10; instruction_in = 32'h00000013; predict_taken_in = 0;
        edge_step();
        checks++;
        if ({PC, instruction, valid} !== {32'h10, 32'h13, 1'b1}) begin
            errors++; $display("FAIL flush_reload PC=%h ins=%h v=%b exp 10 13 1", PC, instruction, valid);
        end
        checks++;
        if (flush_count !== (STATS ? 4'd1 : 4'd0)) begin
            errors++; $display("FAIL flush_count got %0d exp %0d", flush_count, STATS ? 1 : 0);
        end
    endtask

    task automatic test_deferred_flush();
        do_reset();
        PC_in = 32'h20; instruction_in = 32'hCAFEF00D; predict_taken_in = 1;
        edge_step();
        freeze = 1; flush = 1; PC_in = 32'h24;
        edge_step();
        for (int i = 0; i < 2; i++) begin
            flush = (i == 0);
            checks++;
            if ({PC, instruction, predict_taken, valid, flush_pending} !== {32'h20, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1}) begin
                errors++; $display("FAIL pend_hold%0d PC=%h ins=%h pt=%b v=%b fp=%b exp 20 cafef00d 1 1 1", i, PC, instruction, predict_taken, valid, flush_pending);
            end
            edge_step();
        end
        checks++;
        if (flush_pending !== 1'b1 || PC !== 32'h20) begin
            errors++; $display("FAIL pend_hold_last PC=%h fp=%b exp 20 1", PC, flush_pending);
        end
        freeze = 0; flush = 0; PC_in = 32'h28; instruction_in = 32'h0A0A0A0A;
        edge_step();
        checks++;
        if ({PC, instruction, predict_taken, valid, flush_pending} !== 67'h0) begin
            errors++; $display("FAIL pend_bubble PC=%h ins=%h pt=%b v=%b fp=%b exp all zero", PC, instruction, predict_taken, valid, flush_pending);
        end
        edge_step();
        checks++;
        if ({PC, instruction, valid} !== {32'h28, 32'h0A0A0A0A, 1'b1}) begin
            errors++; $display("FAIL pend_reload PC=%h ins=%h v=%b exp 28 0a0a0a0a 1", PC, instruction, valid);
        end
        checks++;
        if ({flush_count, stall_count} !== (STATS ? {4'd1, 4'd3} : 8'h00)) begin
            errors++; $display("FAIL pend_counters fc=%0d sc=%0d exp %0d %0d", flush_count, stall_count, STATS ? 1 : 0, STATS ? 3 : 0);
        end
    endtask

    task automatic test_reset_in_pend();
        do_reset();
        PC_in = 32'h30; instruction_in = 32'h77777777;
        edge_step();
        freeze = 1; flush = 1;
        edge_step();
        checks++;
        if (flush_pending !== 1'b1) begin
            errors++; $display("FAIL rstpend_enter fp=%b exp 1", flush_pending);
        end
        #2;
        rst = 0;
        #1;
        checks++;
        if ({PC, instruction, valid, flush_pending} !== 66'h0) begin
            errors++; $display("FAIL rstpend_async PC=%h ins=%h v=%b fp=%b exp all zero", PC, instruction, valid, flush_pending);
        end
        rst = 1; freeze = 0; flush = 0; PC_in = 32'h34; instruction_in = 32'h00100093; predict_taken_in = 0;
        edge_step();
        checks++;
        if ({PC, instruction, valid, flush_pending} !== {32'h34, 32'h00100093, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rstpend_reload PC=%h ins=%h v=%b fp=%b exp 34 00100093 1 0", PC, instruction, valid, flush_pending);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        freeze = 1;
        for (int i = 1; i <= 20; i++) begin
            edge_step();
            if (i == 14 || i == 15 || i == 20) begin
                checks++;
                if (stall_count !== (STATS ? 4'((i > 15) ? 15 : i) : 4'd0)) begin
                    errors++; $display("FAIL stall_sat_edge%0d got %0d exp %0d", i, stall_count, STATS ? ((i > 15) ? 15 : i) : 0);
                end
            end
        end
        freeze = 0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_freeze();
        test_flush();
        test_deferred_flush();
        test_reset_in_pend();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_id_reg_bp.md
Name: if_id_reg_bp

Overview:
- IF/ID pipeline register sitting directly downstream of the branch-predicting fetch stage.
- Captures fetched PC, instruction and the fetch-time predict-taken bit, and presents them to the ID stage.
- Honours pipeline freeze (stall) and misprediction flush.
- A small FSM defers a flush that arrives during a freeze so the wrong-path instruction is never lost or doubly issued.

Parameters:
- WORD_LEN, 32, width of PC and instruction.
- CNT_W, 32, width of the statistics counters (only used with IFID_STATS_EN).

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  reset, asynchronous, active-low.
- freeze  input  1  hazard stall; hold current contents.
- flush  input  1  misprediction flush from ID; replace contents with a bubble.
- PC_in  input  WORD_LEN  PC from fetch.
- instruction_in  input  WORD_LEN  instruction from fetch.
- predict_taken_in  input  1  fetch-time prediction for PC_in.
- PC  output  WORD_LEN  registered PC to ID.
- instruction  output  WORD_LEN  registered instruction to ID.
- predict_taken  output  1  registered prediction to ID.
- valid  output  1  1 = register holds a real fetched instruction.
- flush_pending  output  1  1 = a flush is latched and waiting for freeze to drop.
- flush_count  output  CNT_W  bubbles inserted (IFID_STATS_EN only).
- stall_count  output  CNT_W  cycles held by freeze (IFID_STATS_EN only).

Behaviour:
- Reset (rst=0, asynchronous):
  - PC=0, instruction=0 (NOP), predict_taken=0, valid=0.
  - State RUN, flush_pending=0, counters=0.
  - Reset asserted mid-operation discards any pending flush immediately.
- All updates occur on the rising edge of clk. Latency from inputs to outputs is 1 cycle. Outputs change only at an edge.
- States are RUN and PEND. flush_pending = (state==PEND).
- RUN:
  - freeze=0, flush=0: load PC_in, instruction_in, predict_taken_in; valid=1.
  - freeze=0, flush=1: load bubble (PC=0, instruction=0, predict_taken=0, valid=0); stay RUN.
  - freeze=1, flush=0: hold all outputs.
  - freeze=1, flush=1: hold all outputs; go to PEND.
- PEND:
  - freeze=1: hold all outputs; stay PEND. A repeated flush has no extra effect.
  - freeze=0: load bubble regardless of flush; go to RUN. Exactly one bubble per pending flush.
- Fetch inputs are never sampled on a bubble-loading edge.
- Bubble encoding is all-zero, which is the NOP the ID stage already decodes.
- valid is purely registered, with no combinational path from inputs.

Optional Feature:
- Macro IFID_STATS_EN.
- Defined:
  - flush_count increments by 1 on every edge that loads a bubble, whether from RUN or from PEND.
  - stall_count increments by 1 on every edge where freeze=1, in either state.
  - Both counters saturate at all-ones and never wrap.
  - Both clear only on reset.
- Not defined:
  - Counter logic is absent; flush_count and stall_count are tied to 0.
  - All other behaviour is identical.

Test Plan:
1. Reset then release, freeze=0, flush=0, PC_in=0x4, instruction_in=0x20010005, predict_taken_in=1 -> after 1 edge PC=0x4, instruction=0x20010005, predict_taken=1, valid=1.
2. Register holds PC 0x8; freeze=1 for 3 edges while PC_in changes -> outputs stay PC=0x8. With IFID_STATS_EN, stall_count=3.
3. freeze=0, flush=1 for 1 edge -> PC=0, instruction=0, predict_taken=0, valid=0. Next edge with flush=0, PC_in=0x10 -> PC=0x10, valid=1. With IFID_STATS_EN, flush_count=1.
4. freeze=1 with flush=1 on 1 edge, then freeze held 2 more edges, then freeze=0 with flush=0:
   - Prior contents held throughout the freeze; flush_pending=1.
   - First unfrozen edge loads the bubble and flush_pending=0.
   - Following edge loads PC_in. flush_count=1, not 2.
5. State PEND, rst pulsed low between edges -> outputs clear immediately and flush_pending=0. After release, first edge loads PC_in normally with no bubble.
6. With IFID_STATS_EN and CNT_W=4, hold freeze=1 for 20 edges -> stall_count=0xF and stays there.
